pkt_merge_arbiter: RTL and testbench

Packet-aware round-robin arbiter that merges two beat streams (153-bit beats, EOP flag in the MSB) onto one registered output stream. It grants an input at a packet boundary and holds the grant until that packet's EOP beat has been accepted, so packets never interleave. It sits between the two packet sources and the packet-merge datapath, sequencing which port the datapath's output carries.

---
 rtl/pkt_merge_arbiter.sv | 99 +++++++++
 tb/tb_pkt_merge_arbiter.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/pkt_merge_arbiter.sv
// Packet-aware round-robin merge of two beat streams onto one registered output.
// A port is locked at a packet boundary and held until its EOP beat is accepted.
module pkt_merge_arbiter #(
    parameter int DATA_W  = 153,
    parameter int EOP_BIT = 152,
    parameter int CNT_W   = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] in0_data,
    input  logic              in0_valid,
    output logic              in0_ready,
    input  logic [DATA_W-1:0] in1_data,
    input  logic              in1_valid,
    output logic              in1_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [1:0]        grant,
    output logic              busy,
    output logic [CNT_W-1:0]  pkt_cnt0,
    output logic [CNT_W-1:0]  pkt_cnt1
);

    localparam logic [1:0] IDLE  = 2'b00;
    localparam logic [1:0] LOCK0 = 2'b01;
    localparam logic [1:0] LOCK1 = 2'b10;

    logic [1:0] state;
    logic       last_served;
    logic       load;
    logic       acc0;
    logic       acc1;
    logic       eop0;
    logic       eop1;

    // The output register can take a new beat when empty or being drained.
    assign load      = !out_valid || out_ready;
    assign in0_ready = (state == LOCK0) && load;
    assign in1_ready = (state == LOCK1) && load;
    assign acc0      = in0_valid && in0_ready;
    assign acc1      = in1_valid && in1_ready;
    assign eop0      = acc0 && in0_data[EOP_BIT];
    assign eop1      = acc1 && in1_data[EOP_BIT];

    assign grant = {state == LOCK1, state == LOCK0};
    assign busy  = (state != IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            last_served <= 1'b1;
            pkt_cnt0    <= '0;
            pkt_cnt1    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    // On a tie the port that was not served last wins.
                    if (in0_valid && (!in1_valid || last_served)) begin
                        state <= LOCK0;
                    end else if (in1_valid) begin
                        state <= LOCK1;
                    end
                end
                LOCK0: begin
                    if (eop0) begin
                        state       <= IDLE;
                        last_served <= 1'b0;
                        pkt_cnt0    <= pkt_cnt0 + CNT_W'(1);
                    end
                end
                LOCK1: begin
                    if (eop1) begin
                        state       <= IDLE;
                        last_served <= 1'b1;
                        pkt_cnt1    <= pkt_cnt1 + CNT_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_data  <= '0;
            out_valid <= 1'b0;
        end else if (acc0) begin
            out_data  <= in0_data;
            out_valid <= 1'b1;
        end else if (acc1) begin
            out_data  <= in1_data;
            out_valid <= 1'b1;
        end else if (load) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_pkt_merge_arbiter.sv
// Randomized bench for pkt_merge_arbiter against a packet-level reference model.
module tb_pkt_merge_arbiter;

    localparam int DATA_W  = 153;
    localparam int EOP_BIT = 152;
    localparam int CNT_W   = 8;

    logic              clk = 1'b0;
    logic              reset;
    logic [DATA_W-1:0] in0_data;
    logic              in0_valid;
    logic              in0_ready;
    logic [DATA_W-1:0] in1_data;
    logic              in1_valid;
    logic              in1_ready;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready;
    logic [1:0]        grant;
    logic              busy;
    logic [CNT_W-1:0]  pkt_cnt0;
    logic [CNT_W-1:0]  pkt_cnt1;

    always #5 clk = ~clk;

    pkt_merge_arbiter #(
        .DATA_W (DATA_W),
        .EOP_BIT(EOP_BIT),
        .CNT_W  (CNT_W)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .in0_data (in0_data),
        .in0_valid(in0_valid),
        .in0_ready(in0_ready),
        .in1_data (in1_data),
        .in1_valid(in1_valid),
        .in1_ready(in1_ready),
        .out_data (out_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .grant    (grant),
        .busy     (busy),
        .pkt_cnt0 (pkt_cnt0),
        .pkt_cnt1 (pkt_cnt1)
    );

    int n_vec = 0;
    int n_bad = 0;

    // Reference model: owner is -1 (nobody), 0 or 1.
    int                owner;
    int                mlast;
    bit                mov;
    logic [DATA_W-1:0] mdata;
    int                mcnt [2];
    logic [DATA_W-1:0] beat [2];
    int                left [2];
    int                fixlen = 0;
    int                maxlen = 4;

    task automatic check(input string tag, input logic [DATA_W-1:0] got, input logic [DATA_W-1:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [DATA_W-1:0] rand_word();
        return DATA_W'({$urandom, $urandom, $urandom, $urandom, $urandom});
    endfunction

    task automatic new_beat(input int p);
        logic [DATA_W-1:0] b;
        if (left[p] == 0) left[p] = (fixlen > 0) ? fixlen : int'($urandom_range(maxlen, 1));
        left[p]--;
        b = rand_word();
        b[EOP_BIT] = (left[p] == 0);
        beat[p] = b;
    endtask

    task automatic model_reset();
        owner = -1;
        mlast = 1;
        mov = 1'b0;
        mdata = '0;
        mcnt[0] = 0;
        mcnt[1] = 0;
        left[0] = 0;
        left[1] = 0;
        new_beat(0);
        new_beat(1);
    endtask

    task automatic check_outputs(input string pfx);
        logic [1:0] eg;
        eg = {owner == 1, owner == 0};
        check({pfx, "_out_valid"}, DATA_W'(out_valid), DATA_W'(mov));
        check({pfx, "_out_data"}, out_data, mdata);
        check({pfx, "_grant"}, DATA_W'(grant), DATA_W'(eg));
        check({pfx, "_busy"}, DATA_W'(busy), DATA_W'(owner != -1));
        check({pfx, "_pkt_cnt0"}, DATA_W'(pkt_cnt0), DATA_W'(mcnt[0]));
        check({pfx, "_pkt_cnt1"}, DATA_W'(pkt_cnt1), DATA_W'(mcnt[1]));
    endtask

    // Called at a falling edge; returns at the next falling edge.
    task automatic run_cycle(input int pv0, input int pv1, input int pr);
        bit eload, er0, er1, a0, a1;
        int prev, p;
        in0_valid = (int'($urandom_range(99)) < pv0);
        in1_valid = (int'($urandom_range(99)) < pv1);
        out_ready = (int'($urandom_range(99)) < pr);
        in0_data  = in0_valid ? beat[0] : rand_word();
        in1_data  = in1_valid ? beat[1] : rand_word();
        eload = !mov || out_ready;
        er0 = (owner == 0) && eload;
        er1 = (owner == 1) && eload;
        #1;
        check("in0_ready", DATA_W'(in0_ready), DATA_W'(er0));
        check("in1_ready", DATA_W'(in1_ready), DATA_W'(er1));
        @(posedge clk);
        prev = owner;
        a0 = in0_valid && er0;
        a1 = in1_valid && er1;
        if (a0 || a1) begin
            p = a0 ? 0 : 1;
            mov = 1'b1;
            mdata = beat[p];
            if (beat[p][EOP_BIT]) begin
                owner = -1;
                mlast = p;
                mcnt[p] = (mcnt[p] + 1) % (1 << CNT_W);
            end
            new_beat(p);
        end else if (eload) begin
            mov = 1'b0;
        end
        if (prev == -1) begin
            if (in0_valid && in1_valid) owner = (mlast == 0) ? 1 : 0;
            else if (in0_valid) owner = 0;
            else if (in1_valid) owner = 1;
        end
        #1;
        check_outputs("cyc");
        @(negedge clk);
    endtask

    task automatic run(input int n, input int pv0, input int pv1, input int pr);
        for (int i = 0; i < n; i++) run_cycle(pv0, pv1, pr);
    endtask

    task automatic apply_reset();
        in0_valid = 1'b0;
        in1_valid = 1'b0;
        out_ready = 1'b0;
        reset = 1'b1;
        #2;
        model_reset();
        check_outputs("rst");
        check("rst_in0_ready", DATA_W'(in0_ready), DATA_W'(0));
        check("rst_in1_ready", DATA_W'(in1_ready), DATA_W'(0));
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        bit found;
        reset = 1'b1;
        in0_valid = 1'b0;
        in1_valid = 1'b0;
        in0_data = '0;
        in1_data = '0;
        out_ready = 1'b0;
        #2;
        apply_reset();

        // Single 3-beat packets on port 0
        fixlen = 3;
        run(12, 100, 0, 100);

        // Both ports saturated with 2-beat packets: strict alternation from port 0
        apply_reset();
        fixlen = 2;
        run(24, 100, 100, 100);

        // Downstream stall in the middle of a long port-0 packet
        apply_reset();
        fixlen = 8;
        run(4, 100, 0, 100);
        run(5, 100, 0, 0);
        run(12, 100, 0, 100);

        // Back-to-back single-beat packets on port 1
        apply_reset();
        fixlen = 1;
        run(12, 0, 100, 100);

        // Random mixed traffic with valid gaps and backpressure
        apply_reset();
        fixlen = 0;
        maxlen = 4;
        run(400, 70, 60, 70);

        // Asynchronous reset while beat 2 of a 4-beat port-1 packet is pending
        apply_reset();
        fixlen = 4;
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            if (owner == 1 && left[1] == 2) found = 1'b1;
            else run_cycle(0, 100, 100);
        end
        check("reset_setup_reached", DATA_W'(found), DATA_W'(1));
        #3;
        reset = 1'b1;
        #1;
        model_reset();
        check_outputs("async_rst");
        @(posedge clk);
        #2;
        reset = 1'b0;
        @(negedge clk);
        run(10, 100, 100, 100);

        // Counter wrap on port 0, port 1 untouched
        apply_reset();
        fixlen = 1;
        run(2 * (1 << CNT_W) + 10, 100, 0, 100);
        check("wrap_cnt1_zero", DATA_W'(pkt_cnt1), DATA_W'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
